// File: rtl/stream_mux_pkg.sv
// ============================================================================
// Module   : stream_mux_pkg
// Brief    : Shared constants for the round-robin stream multiplexer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stream_mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; searches ptr+1 .. ptr (wrapped).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int SELW   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SELW-1:0]   grant_idx,
    output logic              grant_any
);

    logic [SELW-1:0] w_cand [NUM_CH];

    // Candidate k is the channel (k+1) places after ptr; k=0 has highest priority.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cand
        assign w_cand[k] = SELW'((int'(ptr) + k + 1) % NUM_CH);
    end

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                grant_idx = w_cand[k];
                grant_any = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_onehot
        assign grant[i] = grant_any && (grant_idx == SELW'(i));
    end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module   : stream_mux_rr
// Brief    : Registered N:1 valid/ready stream mux, fixed-select or round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SELW   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SELW-1:0]         sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SELW-1:0]   r_ptr;
    logic [NUM_CH-1:0] w_arb_grant;
    logic [SELW-1:0]   w_arb_idx;
    logic              w_arb_any;
    logic [NUM_CH-1:0] w_fix_grant;
    logic [NUM_CH-1:0] w_grant;
    logic [SELW-1:0]   w_grant_idx;
    logic              w_grant_any;
    logic              w_can_load;
    logic [WIDTH-1:0]  w_mux_data;

    rr_arbiter #(
        .NUM_CH    (NUM_CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .grant_any (w_arb_any)
    );

    // An out-of-range sel matches no channel, so it never grants.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_fix
        assign w_fix_grant[i] = (sel == SELW'(i)) && in_valid[i];
    end

    assign w_grant     = (mode == MODE_RR) ? w_arb_grant : w_fix_grant;
    assign w_grant_idx = (mode == MODE_RR) ? w_arb_idx   : sel;
    assign w_grant_any = (mode == MODE_RR) ? w_arb_any   : |w_fix_grant;
    assign w_can_load  = !out_valid || out_ready;
    assign in_ready    = (rst_n && w_can_load) ? w_grant : '0;

    always_comb begin
        w_mux_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_mux_data = w_mux_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ptr starts at the last channel so channel 0 wins the first RR search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            r_ptr     <= SELW'(NUM_CH - 1);
        end else if (w_can_load) begin
            if (w_grant_any) begin
                out_valid <= 1'b1;
                out_data  <= w_mux_data;
                out_ch    <= w_grant_idx;
                if (mode == MODE_RR) begin
                    r_ptr <= w_grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// Module   : tb_stream_mux_rr
// Brief    : Self-checking bench: reference model for 4x8, scoreboard for 3x16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int WB = 16;
    localparam int NB = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    logic           b_mode;
    logic [1:0]     b_sel;
    logic [NB*WB-1:0] b_in_data;
    logic [NB-1:0]  b_in_valid;
    logic [NB-1:0]  b_in_ready;
    logic [WB-1:0]  b_out_data;
    logic [1:0]     b_out_ch;
    logic           b_out_valid;
    logic           b_out_ready;

    int n_tests;
    int n_fail;

    int m_valid, m_data, m_ch, m_ptr;
    int sbq[$];
    int seq [NB];

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .NUM_CH(N)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(WB), .NUM_CH(NB)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = N - 1;
    endtask

    // Channel the reference would serve this cycle, or -1.
    function automatic int model_grant();
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
            return -1;
        end
        if (int'(sel) < N && in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    // Called at posedge+1 after inputs are set; returns at the next posedge+1.
    task automatic tick(input string tag);
        int         g;
        logic       can;
        logic [N-1:0] er;
        #1;
        g   = model_grant();
        can = (m_valid == 0) || out_ready;
        er  = '0;
        if (rst_n && can && g >= 0) er[g] = 1'b1;
        chk({tag, ":in_ready"}, in_ready, er);
        @(posedge clk);
        if (rst_n && can) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = int'(in_data[g*W +: W]);
                m_ch    = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk({tag, ":out_valid"}, out_valid, m_valid);
        chk({tag, ":out_data"}, out_data, m_data);
        chk({tag, ":out_ch"}, out_ch, m_ch);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ":out_valid"}, out_valid, 0);
        chk({tag, ":in_ready"}, in_ready, 0);
        chk({tag, ":out_data"}, out_data, 0);
        chk({tag, ":out_ch"}, out_ch, 0);
    endtask

    // One scoreboard cycle for the 3-channel, 16-bit instance.
    task automatic b_cycle();
        int exp_v;
        #1;
        chk("b_onehot", ($countones(b_in_ready) <= 1), 1);
        if (b_mode == 1'b0 && b_sel == 2'd3) chk("b_sel3_nogrant", b_in_ready, 0);
        if (b_out_valid && b_out_ready) begin
            chk("b_no_dup", (sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                exp_v = sbq.pop_front();
                chk("b_beat", (int'(b_out_ch) << 16) | int'(b_out_data), exp_v);
            end
        end
        for (int c = 0; c < NB; c++) begin
            if (b_in_valid[c] && b_in_ready[c]) begin
                sbq.push_back((c << 16) | int'(b_in_data[c*WB +: WB]));
                seq[c]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0;
        in_data = {8'd2, 8'd5, 8'd6, 8'd7};
        in_valid = 4'hF; out_ready = 1'b1;
        b_mode = 1'b1; b_sel = 2'd0; b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b1;
        for (int c = 0; c < NB; c++) seq[c] = 0;
        model_reset();

        tick("reset0");
        tick("reset1");
        rst_n = 1'b1;
        tick("rr_first");

        mode = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = 2'(s);
            tick("fixed_sweep");
        end
        in_valid = 4'b1101; sel = 2'd1;
        tick("fixed_invalid");

        mode = 1'b1; in_valid = 4'hF;
        for (int i = 0; i < 8; i++) tick("rr_all");
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) tick("rr_1_3");

        in_valid = 4'hF; in_data = {4{8'h55}};
        tick("bp_load");
        in_data = 32'h11223344; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick("bp_hold");
        out_ready = 1'b1;
        tick("bp_release");

        tick("switch_rr");
        mode = 1'b0; sel = 2'd2;
        tick("switch_fixed");
        tick("switch_fixed2");

        async_reset("rst_mid");
        tick("rst_low");
        rst_n = 1'b1; mode = 1'b1;
        tick("rst_rr_first");

        for (int i = 0; i < 300; i++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick("rand_a");
        end

        for (int i = 0; i < 400; i++) begin
            b_mode = (i < 250) ? 1'b1 : 1'b0;
            b_sel  = (i < 320) ? 2'd3 : 2'($urandom_range(0, 3));
            b_in_valid  = 3'($urandom);
            b_out_ready = 1'($urandom);
            for (int c = 0; c < NB; c++)
                b_in_data[c*WB +: WB] = 16'((c << 12) | (seq[c] & 12'hfff));
            b_cycle();
        end
        b_in_valid = '0; b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) b_cycle();
        chk("b_no_loss", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
